// File: rtl/apb_master_pkg.sv
// Shared types for the APB master bridge: FSM states, default bus widths, response record.
// No logic, no latency, no backpressure.
package apb_master_pkg;

    localparam int APB_ADDR_WIDTH_DEF = 32;
    localparam int APB_DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

    typedef struct packed {
        logic [APB_DATA_WIDTH_DEF-1:0] rdata;
        logic                          err;
        logic                          timeout;
    } apb_mst_rsp_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Request port plus APB bus of the bridge; master = bridge side, slave = requester/peripheral side.
// Pure wiring, no latency, no backpressure of its own.
interface apb_master_bridge_if #(
    parameter int APB_ADDR_WIDTH = apb_master_pkg::APB_ADDR_WIDTH_DEF,
    parameter int APB_DATA_WIDTH = apb_master_pkg::APB_DATA_WIDTH_DEF
);
    logic                      req_i;
    logic                      we_i;
    logic [APB_ADDR_WIDTH-1:0] addr_i;
    logic [APB_DATA_WIDTH-1:0] wdata_i;
    logic                      gnt_o;
    logic                      rvalid_o;
    logic [APB_DATA_WIDTH-1:0] rdata_o;
    logic                      err_o;
    logic                      timeout_o;
    logic                      busy_o;

    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [APB_DATA_WIDTH-1:0] PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [APB_DATA_WIDTH-1:0] PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        input  req_i, we_i, addr_i, wdata_i, PRDATA, PREADY, PSLVERR,
        output gnt_o, rvalid_o, rdata_o, err_o, timeout_o, busy_o,
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

    modport slave (
        output req_i, we_i, addr_i, wdata_i, PRDATA, PREADY, PSLVERR,
        input  gnt_o, rvalid_o, rdata_o, err_o, timeout_o, busy_o,
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

endinterface

// File: rtl/apb_mst_timeout_cnt.sv
// Saturating wait-state counter; expired is combinational and fires on the en cycle that reaches the limit.
// One-cycle update latency; no backpressure, TIMEOUT_CYCLES=0 never expires.
module apb_mst_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] SAT  = CW'((TIMEOUT_CYCLES == 0) ? 1 : TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = SAT - CW'(1);
    localparam bit            ENABLED = (TIMEOUT_CYCLES != 0);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != SAT)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // cnt_q counts waits already seen, so this wait is the TIMEOUT_CYCLES-th one
    assign expired = ENABLED && en && (cnt_q == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// req/gnt/rvalid to single-APB-transfer bridge, one outstanding; rvalid 3 cycles after gnt plus slave waits.
// Backpressure: gnt only in IDLE; PREADY waits stretch ACCESS until completion or timeout abort.
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = APB_ADDR_WIDTH_DEF,
    parameter int APB_DATA_WIDTH = APB_DATA_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    apb_master_bridge_if.master bus
);

    apb_mst_state_e state_q, state_d;

    logic [APB_ADDR_WIDTH-1:0] paddr_q;
    logic [APB_DATA_WIDTH-1:0] pwdata_q;
    logic                      pwrite_q;
    apb_mst_rsp_t              rsp_q;

    logic grant;
    logic wait_cycle;
    logic tmo_hit;
    logic psel, penable, rvalid, gnt, busy;

    assign grant      = (state_q == IDLE) && bus.req_i;
    assign wait_cycle = (state_q == ACCESS) && !bus.PREADY;

    apb_mst_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk    (HCLK),
        .rst_n  (HRESETn),
        .clr    (grant),
        .en     (wait_cycle),
        .expired(tmo_hit)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_i) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (bus.PREADY || tmo_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        psel    = 1'b0;
        penable = 1'b0;
        rvalid  = 1'b0;
        gnt     = 1'b0;
        busy    = (state_q != IDLE);
        case (state_q)
            IDLE:   gnt = bus.req_i;
            SETUP:  psel = 1'b1;
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            RESP:   rvalid = 1'b1;
            default: ;
        endcase
    end

    // Bus fields only change on a grant, so they stay put through SETUP/ACCESS and idle periods
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            rsp_q    <= '0;
        end else begin
            if (grant) begin
                paddr_q  <= bus.addr_i;
                pwdata_q <= bus.wdata_i;
                pwrite_q <= bus.we_i;
            end
            if (state_q == ACCESS) begin
                // Completion takes priority over a timeout expiring in the same cycle
                if (bus.PREADY) begin
                    rsp_q.rdata   <= pwrite_q ? '0 : bus.PRDATA;
                    rsp_q.err     <= bus.PSLVERR;
                    rsp_q.timeout <= 1'b0;
                end else if (tmo_hit) begin
                    rsp_q <= '{rdata: '0, err: 1'b1, timeout: 1'b1};
                end
            end
        end
    end

    assign bus.gnt_o     = gnt;
    assign bus.rvalid_o  = rvalid;
    assign bus.busy_o    = busy;
    assign bus.rdata_o   = rsp_q.rdata;
    assign bus.err_o     = rsp_q.err;
    assign bus.timeout_o = rsp_q.timeout;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PSEL      = psel;
    assign bus.PENABLE   = penable;

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB initiator that turns a simple req/gnt/rvalid request port into single APB transfers for the peripheral slaves on the APB bus.
- Lets an internal engine, such as an MMU/accelerator sequencer or a test driver, program and read APB slave register windows without going through the core.
- Allows one outstanding transfer at a time.
- Handles slave wait states, slave errors and a bus-hang timeout.

Parameters:
- APB_ADDR_WIDTH, 32, width of PADDR and addr_i.
- APB_DATA_WIDTH, 32, width of PWDATA, PRDATA, wdata_i and rdata_o.
- TIMEOUT_CYCLES, 255, maximum number of ACCESS cycles with PREADY low before the bridge aborts the transfer. 0 disables the timeout.

Ports:
- HCLK input 1: system clock. All logic is on the rising edge.
- HRESETn input 1: asynchronous active-low reset.
- req_i input 1: request valid.
- we_i input 1: 1 = write, 0 = read.
- addr_i input APB_ADDR_WIDTH: byte address.
- wdata_i input APB_DATA_WIDTH: write data.
- gnt_o output 1: request accepted this cycle.
- rvalid_o output 1: one-cycle response pulse.
- rdata_o output APB_DATA_WIDTH: read data, valid while rvalid_o is high.
- err_o output 1: response error (PSLVERR or timeout), valid while rvalid_o is high.
- timeout_o output 1: high with rvalid_o when the error cause is the timeout.
- busy_o output 1: high whenever the state is not IDLE.
- PADDR output APB_ADDR_WIDTH
- PWDATA output APB_DATA_WIDTH
- PWRITE output 1
- PSEL output 1
- PENABLE output 1
- PRDATA input APB_DATA_WIDTH
- PREADY input 1
- PSLVERR input 1

Behaviour:
- Reset: every register and output is 0 and the state is IDLE. Reset asserted mid-transfer drops PSEL/PENABLE immediately and no response is issued.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - gnt_o = req_i (combinational).
  - On req_i, register addr_i, wdata_i and we_i into PADDR, PWDATA and PWRITE, then go to SETUP.
- SETUP: PSEL=1, PENABLE=0. Always go to ACCESS next cycle.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=1: capture PSLVERR into err and, for reads only, PRDATA into rdata (writes return rdata 0). Go to RESP.
  - PREADY=0: increment the wait counter and stay.
  - Wait counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0): deassert PSEL/PENABLE next cycle, err=1, timeout=1, rdata=0, go to RESP.
  - PREADY=1 on the same cycle the counter reaches the limit: the completion wins and no timeout is flagged.
- RESP: rvalid_o=1 for exactly one cycle with rdata_o, err_o and timeout_o. PSEL=0. gnt_o=0. Go to IDLE.
- Wait counter:
  - Width is $clog2(TIMEOUT_CYCLES+1), minimum 1.
  - Cleared on entry to SETUP. Saturates and never wraps.
- Bus stability:
  - PADDR, PWDATA and PWRITE are constant from SETUP through ACCESS.
  - In IDLE and RESP they hold their last values; they never toggle without a new grant.
  - PENABLE is never high unless PSEL is high.
- Latency and throughput:
  - Grant on cycle 0 gives SETUP on 1 and ACCESS on 2.
  - With zero wait states, rvalid_o is on cycle 3; each slave wait state adds one cycle.
  - Maximum throughput is one transfer per 4 cycles.
  - A req_i held high through RESP is granted in the following IDLE cycle.
- rdata_o, err_o and timeout_o are registered. Outside rvalid_o they hold their values but are don't-care to the requester.
- No address decoding: every address is issued as given. The low two bits are passed through unchanged.

Decomposition:
- Package apb_master_pkg holds:
  - the state enum type apb_mst_state_e (IDLE, SETUP, ACCESS, RESP);
  - localparams APB_ADDR_WIDTH_DEF=32 and APB_DATA_WIDTH_DEF=32;
  - the response struct apb_mst_rsp_t {rdata, err, timeout}.
- One sub-module: apb_mst_timeout_cnt, a saturating counter with clear/enable inputs and an expired output.
- The FSM and datapath stay in apb_master_bridge.

Test Plan:
- Write 0x1A10_3000 with data 0x0000_0005 and PREADY tied high -> PSEL high on cycles 1-2, PENABLE high on cycle 2, PWRITE=1, rvalid_o on cycle 3 with err_o=0, busy_o low on cycle 4.
- Read 0x1A10_3104 with PREADY low for 3 ACCESS cycles, then high with PRDATA=0x1234_5678 -> rvalid_o on cycle 6, rdata_o=0x1234_5678, PADDR stable on cycles 1-5.
- Read with PSLVERR=1 and PREADY=1 -> rvalid_o on cycle 3 with err_o=1 and timeout_o=0.
- TIMEOUT_CYCLES=8 with PREADY stuck low -> PSEL drops after 8 ACCESS cycles, then a single rvalid_o with err_o=1, timeout_o=1, rdata_o=0; a next request proceeds normally.
- HRESETn asserted during ACCESS -> PSEL and PENABLE go to 0 asynchronously and no rvalid_o is seen. After release, a new write completes in 3 cycles.
- req_i held high for 3 back-to-back writes to 0x1A10_3100, 0x1A10_3104 and 0x1A10_3108 -> gnt_o pulses on cycles 0, 4 and 8, three rvalid_o pulses, addresses issued in order.
